// File: rtl/led_decoder_3to8.sv
// Registered 3-to-8 line decoder with active-low outputs and 74x138-style enable gating.
// Optional LED_HOLD_EN macro: a disabled enable code holds the previous led value instead of blanking.
module led_decoder_3to8 #(
   parameter int         SEL_W   = 3,
   parameter logic [2:0] EN_CODE = 3'b100
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [2:0]             enable,
   input  logic [SEL_W-1:0]       switch,
   output logic [(2**SEL_W)-1:0]  led
);

   localparam int OUT_W = 2**SEL_W;

   logic [OUT_W-1:0] decoded;
   logic [OUT_W-1:0] next_led;

   // One-cold decode: only the bit addressed by switch is driven low (lit).
   always_comb begin
      decoded = '1;
      for (int i = 0; i < OUT_W; i++) begin
         if (switch == SEL_W'(i)) begin
            decoded[i] = 1'b0;
         end
      end
   end

   always_comb begin
      next_led = decoded;
      if (enable != EN_CODE) begin
`ifdef LED_HOLD_EN
         next_led = led;
`else
         next_led = '1;
`endif
      end
   end

   // Reset is asynchronous so the LEDs blank immediately, independent of clk.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         led <= '1;
      end else begin
         led <= next_led;
      end
   end

endmodule

// File: tb/tb_led_decoder_3to8.sv
// Self-checking bench for led_decoder_3to8: directed literal checks plus a randomized run
// compared every cycle against an arithmetic reference model (honours LED_HOLD_EN).
module tb_led_decoder_3to8;

   localparam logic [2:0] EN_CODE = 3'b100;

   logic       clk;
   logic       rst;
   logic [2:0] enable;
   logic [2:0] switch;
   logic [7:0] led;

   int checks = 0;
   int errors = 0;
   bit compare_on = 0;
   logic [7:0] model_led = 8'hFF;

   led_decoder_3to8 #(.SEL_W(3), .EN_CODE(EN_CODE)) dut (
      .clk    (clk),
      .rst    (rst),
      .enable (enable),
      .switch (switch),
      .led    (led)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: the lit LED index is the switch value, computed arithmetically.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         model_led = 8'hFF;
      end else if (enable == EN_CODE) begin
         model_led = 8'hFF - (8'd1 << switch);
      end else begin
`ifndef LED_HOLD_EN
         model_led = 8'hFF;
`endif
      end
   end

   task automatic checkOutput(input string name, input logic [7:0] expected);
      checks++;
      if (led !== expected) begin
         errors++;
         $display("[TB] FAIL %s: led=%h expected=%h at %0t", name, led, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic [2:0] en, input logic [2:0] sw);
      @(negedge clk);
      rst    = r;
      enable = en;
      switch = sw;
   endtask

   always @(posedge clk) begin
      #1;
      if (compare_on) checkOutput("model", model_led);
   end

   initial begin
      logic [7:0] step_exp [8];
      logic [2:0] off_codes [5];
      step_exp  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
      off_codes = '{3'b000, 3'b001, 3'b101, 3'b110, 3'b111};

      rst    = 1'b1;
      enable = 3'b000;
      switch = 3'b000;
      #1;
      rst = 1'b0;
      #1;
      checkOutput("reset_async", 8'hFF);
      compare_on = 1;

      // Reset held with random inputs, including a valid enable code.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, (i == 1) ? EN_CODE : 3'($urandom), 3'($urandom));
         #2;
         checkOutput("reset_midcycle", 8'hFF);
      end

      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, EN_CODE, 3'(i));
         @(posedge clk); #1;
         checkOutput($sformatf("decode_%0d", i), step_exp[i]);
      end

`ifndef LED_HOLD_EN
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, EN_CODE, 3'd6);
         @(posedge clk); #1;
         checkOutput("pre_disable", 8'hBF);
         applyStimulus(1'b1, off_codes[i], 3'd3);
         @(posedge clk); #1;
         checkOutput($sformatf("disabled_%b", off_codes[i]), 8'hFF);
      end
`else
      applyStimulus(1'b1, EN_CODE, 3'd2);
      @(posedge clk); #1;
      checkOutput("hold_load", 8'hFB);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, off_codes[i], 3'd6);
         @(posedge clk); #1;
         checkOutput($sformatf("hold_%b", off_codes[i]), 8'hFB);
      end
      applyStimulus(1'b0, 3'b010, 3'd6);
      #1;
      checkOutput("hold_reset", 8'hFF);
`endif

      applyStimulus(1'b1, EN_CODE, 3'd5);
      @(posedge clk); #1;
      checkOutput("mid_reset_pre", 8'hDF);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("mid_reset_async", 8'hFF);
      applyStimulus(1'b1, EN_CODE, 3'd5);
      #1;
      checkOutput("mid_reset_held", 8'hFF);
      @(posedge clk); #1;
      checkOutput("mid_reset_release", 8'hDF);

      // Randomized run: mostly valid enable, occasional other codes and reset pulses.
      for (int i = 0; i < 80; i++) begin
         applyStimulus(($urandom % 5) != 0,
                       (($urandom % 7) == 0) ? 3'($urandom) : EN_CODE,
                       3'($urandom));
      end

      @(posedge clk); #2;
      compare_on = 0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
